// File: rtl/dm_access_ctrl_pkg.sv
// ============================================================================
// dm_access_ctrl_pkg : shared FSM encoding, load-extension codes, timeout limit
// Revision: 1.0
// ============================================================================
`default_nettype none

package dm_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LBU = 3'd1,
    LD_LB  = 3'd2,
    LD_LHU = 3'd3,
    LD_LH  = 3'd4
  } ld_op_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // Unused encodings fold onto a full-word load.
  function automatic ld_op_t norm_ld_op(input logic [2:0] code);
    return (code > 3'd4) ? LD_LW : ld_op_t'(code);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_access_ctrl_load_extender.sv
// ============================================================================
// load_extender : selects the addressed byte/halfword of a read word and
//                 zero- or sign-extends it to 32 bits
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_extender
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  ld_op_t      op,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = offset[1] ? word[31:16] : word[15:0];
    case (op)
      LD_LBU:  result = {24'd0, w_byte};
      LD_LB:   result = {{24{w_byte[7]}}, w_byte};
      LD_LHU:  result = {16'd0, w_half};
      LD_LH:   result = {{16{w_half[15]}}, w_half};
      default: result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
// ============================================================================
// dm_access_ctrl : data-memory access controller (IDLE/REQ/RESP) with lane
//                  placement, alignment check and load extension.
//                  Optional bus timeout enabled by macro DM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        sb,
  input  logic        sh,
  input  logic        sw,
  input  logic        load,
  input  logic [2:0]  load_ext_op,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign_exc,
  output logic        bus_err
);

  state_t      r_state;
  logic        r_is_load;
  ld_op_t      r_ld_op;
  logic [1:0]  r_offset;

  logic        w_store;
  logic        w_access;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_timeout;
  ld_op_t      w_ld_op;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  // Store flags override load; among stores the widest wins.
  always_comb begin
    w_store      = sb | sh | sw;
    w_access     = mem_valid & (load | w_store);
    w_ld_op      = norm_ld_op(load_ext_op);
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = wdata;
    if (sw) begin
      w_misaligned = |addr[1:0];
    end else if (sh) begin
      w_be         = addr[1] ? 4'b1100 : 4'b0011;
      w_wdata      = {2{wdata[15:0]}};
      w_misaligned = addr[0];
    end else if (sb) begin
      w_be         = 4'b0001 << addr[1:0];
      w_wdata      = {4{wdata[7:0]}};
    end else begin
      case (w_ld_op)
        LD_LB, LD_LBU: w_be = 4'b0001 << addr[1:0];
        LD_LH, LD_LHU: begin
          w_be         = addr[1] ? 4'b1100 : 4'b0011;
          w_misaligned = addr[0];
        end
        default:       w_misaligned = |addr[1:0];
      endcase
    end
    w_accept = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    stall    = w_accept | (r_state == ST_REQ);
  end

  load_extender u_load_extender (
    .word   (bus_rdata),
    .offset (r_offset),
    .op     (r_ld_op),
    .result (w_ext)
  );

`ifdef DM_TIMEOUT_EN
  logic [7:0] r_tmo;

  assign w_timeout = (r_tmo == TIMEOUT_LIMIT - 8'd1) & ~bus_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo   <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= (r_state == ST_REQ) & w_timeout;
      if ((r_state == ST_REQ) && !bus_ack && !w_timeout)
        r_tmo <= r_tmo + 8'd1;
      else
        r_tmo <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_is_load    <= 1'b0;
      r_ld_op      <= LD_LW;
      r_offset     <= 2'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
      rdata_out    <= 32'd0;
      rdata_valid  <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= (r_state == ST_IDLE) & w_access & w_misaligned;
      rdata_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_REQ;
            bus_req   <= 1'b1;
            bus_we    <= w_store;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
            r_is_load <= ~w_store;
            r_ld_op   <= w_ld_op;
            r_offset  <= addr[1:0];
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'd0;
            r_state <= ST_RESP;
            if (r_is_load) begin
              rdata_out   <= w_ext;
              rdata_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'd0;
            rdata_out <= 32'd0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// tb_dm_access_ctrl : directed stimulus with an expected-event queue checked
//                     by a monitor process. Timeout case built with DM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dm_access_ctrl;

  localparam int EV_BUS  = 0;
  localparam int EV_LOAD = 1;
  localparam int EV_MIS  = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sb, sh, sw, load;
  logic [2:0]  load_ext_op;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        misalign_exc;
  logic        bus_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   stall_cnt;
  int   req_cnt;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .addr         (addr),
    .wdata        (wdata),
    .sb           (sb),
    .sh           (sh),
    .sw           (sw),
    .load         (load),
    .load_ext_op  (load_ext_op),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .stall        (stall),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic we);
    exp_t e;
    e.kind = kind; e.addr = a; e.be = be; e.data = d; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: actual kind %0d required none", kind);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == EV_BUS && e.kind == EV_BUS) begin
      check("bus_addr", bus_addr, e.addr);
      check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
      check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
      if (e.we) check("bus_wdata", bus_wdata, e.data);
    end else if (kind == EV_LOAD && e.kind == EV_LOAD) begin
      check("rdata_out", rdata_out, e.data);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    @(posedge clk);
    #1;
  endtask

  // flags = {sw, sh, sb, load}
  task automatic present(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] flags, input logic [2:0] op);
    mem_valid = 1'b1; addr = a; wdata = d;
    {sw, sh, sb, load} = flags;
    load_ext_op = op;
  endtask

  task automatic idle_in();
    mem_valid = 1'b0;
    {sw, sh, sb, load} = 4'b0000;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] flags,
                        input logic [2:0] op, input int wait_n, input logic [31:0] rd,
                        input int exp_stall);
    stall_cnt = 0;
    present(a, d, flags, op);
    tick();
    idle_in();
    repeat (wait_n) tick();
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    tick();
    tick();
    check("stall_cycles", stall_cnt, exp_stall);
  endtask

  task automatic misaligned(input logic [31:0] a, input logic [3:0] flags, input logic [2:0] op);
    stall_cnt = 0;
    req_cnt = 0;
    push(EV_MIS, 32'd0, 4'd0, 32'd0, 1'b0);
    present(a, 32'hFFFF_FFFF, flags, op);
    tick();
    idle_in();
    tick();
    tick();
    check("mis_stall_cycles", stall_cnt, 0);
    check("mis_req_cycles", req_cnt, 0);
  endtask

  initial begin
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    mem_valid = 1'b0; addr = 32'd0; wdata = 32'd0;
    {sw, sh, sb, load} = 4'b0000; load_ext_op = 3'd0;

    fork
      forever begin
        @(negedge clk);
        if (bus_req && bus_ack) pop_check(EV_BUS);
        if (rdata_valid)        pop_check(EV_LOAD);
        if (misalign_exc)       pop_check(EV_MIS);
        if (bus_err)            pop_check(EV_ERR);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rdata_out", rdata_out, 32'd0);
    check("rst_flags", {28'd0, rdata_valid, misalign_exc, bus_err, stall}, 32'd0);
    rst = 1'b1;
    tick();

    // sb to byte lane 3, two wait cycles
    push(EV_BUS, 32'h10, 4'b1000, 32'hABAB_ABAB, 1'b1);
    access(32'h13, 32'h0000_00AB, 4'b0010, 3'd0, 2, 32'd0, 4);
    // lb / lbu from lane 1
    push(EV_BUS, 32'h20, 4'b0010, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'hFFFF_FF80, 1'b0);
    access(32'h21, 32'd0, 4'b0001, 3'd2, 0, 32'h0000_8000, 2);
    push(EV_BUS, 32'h20, 4'b0010, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'h0000_0080, 1'b0);
    access(32'h21, 32'd0, 4'b0001, 3'd1, 0, 32'h0000_8000, 2);
    // misaligned lh
    misaligned(32'h03, 4'b0001, 3'd4);
    // sw and sh both set: sw wins
    push(EV_BUS, 32'h40, 4'b1111, 32'h1234_5678, 1'b1);
    access(32'h40, 32'h1234_5678, 4'b1100, 3'd0, 1, 32'd0, 3);
    check("rdata_hold_after_store", rdata_out, 32'h0000_0080);
    // sh upper half
    push(EV_BUS, 32'h40, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    access(32'h42, 32'h0000_BEEF, 4'b0100, 3'd0, 0, 32'd0, 2);
    // halfword and word loads
    push(EV_BUS, 32'h20, 4'b1100, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'hFFFF_8001, 1'b0);
    access(32'h22, 32'd0, 4'b0001, 3'd4, 1, 32'h8001_1234, 3);
    push(EV_BUS, 32'h20, 4'b0011, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'h0000_F234, 1'b0);
    access(32'h20, 32'd0, 4'b0001, 3'd3, 0, 32'h8001_F234, 2);
    push(EV_BUS, 32'h30, 4'b1111, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'hCAFE_BABE, 1'b0);
    access(32'h30, 32'd0, 4'b0001, 3'd6, 0, 32'hCAFE_BABE, 2);
    push(EV_BUS, 32'h20, 4'b1000, 32'd0, 1'b0);
    push(EV_LOAD, 32'd0, 4'd0, 32'h0000_007F, 1'b0);
    access(32'h23, 32'd0, 4'b0001, 3'd2, 0, 32'h7F00_0000, 2);
    // sb beats load
    push(EV_BUS, 32'h10, 4'b0010, 32'h5A5A_5A5A, 1'b1);
    access(32'h11, 32'h0000_005A, 4'b0011, 3'd0, 0, 32'h1111_1111, 2);
    check("rdata_hold_after_sb_load", rdata_out, 32'h0000_007F);
    // more misaligned forms
    misaligned(32'h31, 4'b0001, 3'd0);
    misaligned(32'h42, 4'b1000, 3'd0);
    misaligned(32'h05, 4'b0001, 3'd3);

    // reset during REQ, then a late ack
    present(32'h50, 32'd0, 4'b0001, 3'd0);
    tick();
    idle_in();
    tick();
    check("req_before_rst", {31'd0, bus_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("req_after_async_rst", {31'd0, bus_req}, 32'd0);
    tick();
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    tick();
    tick();
    check("rdata_after_rst", rdata_out, 32'd0);

`ifdef DM_TIMEOUT_EN
    begin
      int k;
      push(EV_ERR, 32'd0, 4'd0, 32'd0, 1'b0);
      present(32'h60, 32'd0, 4'b0001, 3'd0);
      tick();
      idle_in();
      req_cnt = 0;
      k = 0;
      forever begin
        @(negedge clk);
        if (bus_err || k >= 300) break;
        if (bus_req) req_cnt++;
        @(posedge clk);
        #1;
        k++;
      end
      check("timeout_seen", {31'd0, bus_err}, 32'd1);
      check("timeout_req_cycles", req_cnt, 255);
      check("timeout_req_dropped", {31'd0, bus_req}, 32'd0);
      check("timeout_stall", {31'd0, stall}, 32'd0);
      check("timeout_rdata", rdata_out, 32'd0);
      @(posedge clk);
      #1;
      tick();
    end
`endif

    repeat (3) tick();
    check("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
